alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter WAIT_CYC, default 1, SHALL set the cycles alu_en is held before the ALU result is captured (legal range 1-15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 req0_valid/req1_valid  input  1 each  SHALL indicate that the requester presents a command.
REQ-005 req0_ready/req1_ready  output  1 each  SHALL indicate command accept; a transfer is valid&ready in the same cycle.
REQ-006 req0_op/req1_op  input  5 each  SHALL carry the ALU opcode.
REQ-007 req0_a/req1_a and req0_b/req1_b  input  32 each  SHALL carry operands in1 and in2.
REQ-008 rsp0_valid/rsp1_valid  output  1 each  SHALL indicate that a result is available to that requester.
REQ-009 rsp0_ready/rsp1_ready  input  1 each  SHALL indicate result accept.
REQ-010 rsp0_data/rsp1_data  output  33 each  SHALL carry the captured ALU result.
REQ-011 rsp0_err/rsp1_err  output  1 each  SHALL flag a rejected command; valid only with rsp_valid.
REQ-012 alu_en  output  1  SHALL drive the shared ALU enable.
REQ-013 alu_op  output  5  SHALL drive the ALU opcode.
REQ-014 alu_in1/alu_in2  output  32 each  SHALL drive the ALU operands.
REQ-015 alu_out  input  33  SHALL receive the combinational ALU result.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, RESP and no others.
REQ-018 IDLE: when any req_valid is high, the block SHALL assert req_ready to exactly one requester (the grantee) for one cycle, latch its op/a/b and ID, and move to EXEC, or to RESP for a rejected command.
REQ-019 Arbitration SHALL be round-robin: if both are valid, the requester not served last wins; the pointer resets to favour requester 0.
REQ-020 Legal opcodes SHALL be 00000, 00001, 00010, 00100, 01000, 00011, 11000, 00110, 00101 and 01010.
REQ-021 An illegal opcode, or opcode 00101 with b==0, SHALL skip EXEC, set err=1 and set data=0.
REQ-022 EXEC: alu_en=1 for exactly WAIT_CYC cycles; alu_out SHALL be registered on the last EXEC cycle, then the FSM SHALL enter RESP.
REQ-023 alu_op/alu_in1/alu_in2 SHALL hold the latched command from acceptance until the next acceptance; alu_en=0 outside EXEC.
REQ-024 RESP: only the grantee's rsp_valid SHALL be high, with data/err stable until rsp_ready; on valid&ready the FSM SHALL return to IDLE.
REQ-025 req_ready SHALL stay low outside IDLE, so there is at most one outstanding command; new requests wait.
REQ-026 A request dropped before acceptance SHALL have no effect.
REQ-027 Command-to-response latency SHALL be WAIT_CYC+1 cycles (1 cycle for rejected commands), plus response backpressure.

Reset
REQ-028 While rst is high at a clock edge: state=IDLE, pointer=requester 0, and every output 0 (req_ready, rsp_valid, rsp_data, rsp_err, alu_en, alu_op, alu_in1/2, busy).
REQ-029 Reset mid-EXEC or mid-RESP SHALL abandon the transaction with no response issued.

Configuration
REQ-030 With ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests and the pointer SHALL be unused; without it, round-robin per REQ-019 applies.

Verification
REQ-031 Single add: req0 op=00000, a=5, b=7, WAIT_CYC=1 -> rsp0_valid 2 cycles after accept, data=12, err=0.
REQ-032 Contention: both valid continuously with op=00010 -> grants alternate 0,1,0,1 (with the macro: always 0).
REQ-033 Divide by zero: req1 op=00101, a=9, b=0 -> alu_en never asserted, rsp1_valid next cycle, err=1, data=0.
REQ-034 Backpressure: rsp0_ready low for 5 cycles -> rsp0_valid and data held, req1 not granted until the handshake completes.
REQ-035 Reset in EXEC: assert rst during alu_en -> next cycle all outputs 0, FSM IDLE, no rsp_valid afterwards.
REQ-036 Illegal op 11111 from req0 -> err=1, data=0, and the following legal command completes normally.

Source files
------------

// File: rtl/alu_arb.sv
// alu_arb: two-requester front end for one shared ALU.
//
// Requesters present a command (opcode plus two operands) with a valid/ready
// handshake. The arbiter accepts one command at a time, holds alu_en for
// WAIT_CYC cycles, captures the ALU result and returns it to the requester
// that issued the command. Illegal opcodes, and divide with a zero divisor,
// are answered straight away with err=1 and data=0, and the ALU is never
// enabled for them.
//
// Parameters
//   WAIT_CYC            cycles alu_en is held before the result is captured (1-15)
// Build option
//   ALU_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins simultaneous
//                          requests; otherwise arbitration is round-robin.
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b           command channel of requester N
//   rspN_valid/ready/data/err         response channel of requester N
//   alu_en/op/in1/in2, alu_out        shared combinational ALU
//   busy                              high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | waiting for a command; the grantee sees req_ready
// EXEC  | alu_en high, counting down WAIT_CYC cycles
// RESP  | result held for the grantee until rsp_ready

module alu_arb #(
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [32:0] rsp0_data,
  output logic        rsp0_err,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [32:0] rsp1_data,
  output logic        rsp1_err,

  output logic        alu_en,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [32:0] alu_out,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);
  localparam logic [4:0] OP_DIV   = 5'b00101;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000,
      5'b00011, 5'b11000, 5'b00110, 5'b00101, 5'b01010: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        id_q, id_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [32:0] data_q, data_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  // Requester favoured on the next simultaneous request.
  logic        prio_q, prio_d;
`endif

  logic        grant_id;
  logic        accept;
  logic        rsp_hs;
  logic [4:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        cmd_ok;

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_id = !req0_valid;
`else
    if (req0_valid && req1_valid) begin
      grant_id = prio_q;
    end else begin
      grant_id = !req0_valid;
    end
`endif
  end

  // rst gates the combinational ready so nothing is handed out during reset.
  assign accept     = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;
  assign cmd_ok = op_legal(sel_op) && !((sel_op == OP_DIV) && (sel_b == 32'd0));

  assign rsp_hs = (state_q == RESP) && (id_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d   = grant_id;
          op_d   = sel_op;
          a_d    = sel_a;
          b_d    = sel_b;
`ifndef ALU_ARB_FIXED_PRIO_EN
          prio_d = !grant_id;
`endif
          if (cmd_ok) begin
            cnt_d   = CNT_LOAD;
            state_d = EXEC;
          end else begin
            data_d  = 33'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          data_d  = alu_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      op_q    <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      data_q  <= 33'd0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      prio_q  <= prio_d;
`endif
    end
  end

  assign alu_en  = (state_q == EXEC);
  assign alu_op  = op_q;
  assign alu_in1 = a_q;
  assign alu_in2 = b_q;
  assign busy    = (state_q != IDLE);

  assign rsp0_valid = (state_q == RESP) && !id_q;
  assign rsp1_valid = (state_q == RESP) && id_q;
  assign rsp0_data  = data_q;
  assign rsp1_data  = data_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;

endmodule

// File: tb/tb_alu_arb.sv
// Testbench for alu_arb: directed scenarios followed by random traffic, each
// transaction checked against a transaction-level reference model.

module tb_alu_arb;

  localparam int WAIT_CYC = 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [32:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1, alu_in2;
  logic [32:0] alu_out;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int last_served = 1;   // model: requester 0 is favoured after reset

  logic [4:0] legal_ops [10] = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000,
                                 5'b00011, 5'b11000, 5'b00110, 5'b00101, 5'b01010};

  alu_arb #(.WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_en(alu_en), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU: any fixed function of (op, in1, in2) will do.
  function automatic logic [32:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'b00000: alu_fn = {1'b0, a} + {1'b0, b};
      5'b00001: alu_fn = {1'b0, a} - {1'b0, b};
      5'b00010: alu_fn = {1'b0, a & b};
      5'b00100: alu_fn = {1'b0, a | b};
      5'b01000: alu_fn = {1'b0, a ^ b};
      5'b00011: alu_fn = {1'b0, a << b[4:0]};
      5'b11000: alu_fn = {1'b0, a >> b[4:0]};
      5'b00110: alu_fn = {1'b0, a * b};
      5'b00101: alu_fn = (b != 0) ? {1'b0, a / b} : 33'd0;
      5'b01010: alu_fn = {1'b1, ~a};
      default:  alu_fn = 33'h1_5555_5555;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_in1, alu_in2);

  function automatic bit is_legal(input logic [4:0] op);
    bit hit = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) hit = 1'b1;
    return hit;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction. Called at a negedge with the DUT idle. The losing
  // requester keeps its valid up while the DUT is busy and withdraws it just
  // before the response handshake, so it must never be accepted.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input int bp);
    int          w, lat, en_cnt, left;
    bit          rej, seen, done, held_bad, busy_bad;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [32:0] exp_data;
    logic        my_valid, other_valid;
    logic [32:0] my_data;
    logic        my_err;

    if (v0 && v1) w = FIXED_PRIO ? 0 : (last_served == 0 ? 1 : 0);
    else          w = v0 ? 0 : 1;
    op  = (w == 1) ? op1 : op0;
    a   = (w == 1) ? a1  : a0;
    b   = (w == 1) ? b1  : b0;
    rej = !is_legal(op) || (op == 5'b00101 && b == 32'd0);
    exp_data = rej ? 33'd0 : alu_fn(op, a, b);

    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("grant", 64'({req1_ready, req0_ready}), (w == 1) ? 64'd2 : 64'd1);
    @(posedge clk);
    last_served = w;
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (w == 1) req0_valid = 1'b1; else req1_valid = 1'b1;

    lat = 0; en_cnt = 0; left = bp;
    seen = 0; done = 0; held_bad = 0; busy_bad = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      my_valid    = (w == 1) ? rsp1_valid : rsp0_valid;
      other_valid = (w == 1) ? rsp0_valid : rsp1_valid;
      my_data     = (w == 1) ? rsp1_data  : rsp0_data;
      my_err      = (w == 1) ? rsp1_err   : rsp0_err;
      if (alu_en) en_cnt++;
      if (req0_ready || req1_ready || !busy || other_valid) busy_bad = 1'b1;
      if (my_valid) begin
        if (!seen) begin
          seen = 1'b1;
          lat  = c;
          check("rsp_data", 64'(my_data), 64'(exp_data));
          check("rsp_err", 64'(my_err), 64'(rej));
        end else if (my_data !== exp_data || my_err !== rej) begin
          held_bad = 1'b1;
        end
      end
      if (seen && left == 0) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (w == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(posedge clk);
        done = 1'b1;
        break;
      end
      if (seen) left--;
    end
    #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("handshake_done", 64'(done), 64'd1);
    check("latency", 64'(lat), rej ? 64'd1 : 64'(WAIT_CYC + 1));
    check("alu_en_cycles", 64'(en_cnt), rej ? 64'd0 : 64'(WAIT_CYC));
    check("rsp_held", 64'(held_bad), 64'd0);
    check("busy_no_ready", 64'(busy_bad), 64'd0);
    @(negedge clk);
    check("back_idle", 64'({busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                              rsp0_err, rsp1_err, alu_en, busy}), 64'd0);
    check({tag, "_data0"}, 64'(rsp0_data), 64'd0);
    check({tag, "_data1"}, 64'(rsp1_data), 64'd0);
    check({tag, "_alu_op"}, 64'(alu_op), 64'd0);
    check({tag, "_alu_in"}, {alu_in1, alu_in2}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         v0, v1, quiet_bad;
    logic [4:0] o0, o1;
    logic [31:0] x0, y0, x1, y1;

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_quiet", 64'({busy, req1_ready, req0_ready}), 64'd0);

    // single add
    run_txn(1, 0, 5'b00000, 32'd5, 32'd7, 5'b00000, 32'd0, 32'd0, 0);
    // divide by zero from requester 1
    run_txn(0, 1, 5'b00000, 32'd0, 32'd0, 5'b00101, 32'd9, 32'd0, 0);
    // legal divide
    run_txn(0, 1, 5'b00000, 32'd0, 32'd0, 5'b00101, 32'd100, 32'd7, 0);
    // illegal opcode, then a normal command
    run_txn(1, 0, 5'b11111, 32'd3, 32'd4, 5'b00000, 32'd0, 32'd0, 0);
    run_txn(1, 0, 5'b00001, 32'd3, 32'd4, 5'b00000, 32'd0, 32'd0, 0);
    // backpressure with requester 1 waiting
    run_txn(1, 1, 5'b01000, 32'hF0F0_1234, 32'h0FF0_4321, 5'b00100, 32'd1, 32'd2, 5);
    // contention
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 5'b00010, 32'hFFFF_0000 + i, 32'h00FF_FF00, 5'b00010, 32'h1234_5678, 32'hFFFF_FFFF, 0);

    // reset while the ALU is enabled
    req0_valid = 1; req0_op = 5'b00000; req0_a = 32'd1; req0_b = 32'd2;
    @(posedge clk);
    #1;
    req0_valid = 0;
    @(negedge clk);
    check("alu_en_before_rst", 64'(alu_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_exec_rst");
    rst = 1'b0;
    last_served = 1;
    quiet_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy) quiet_bad = 1'b1;
    end
    check("no_rsp_after_rst", 64'(quiet_bad), 64'd0);
    // pointer is back at requester 0
    run_txn(1, 1, 5'b00000, 32'd10, 32'd20, 5'b00000, 32'd30, 32'd40, 0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      o0 = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 9)] : 5'($urandom);
      o1 = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 9)] : 5'($urandom);
      x0 = $urandom; x1 = $urandom;
      y0 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      y1 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_txn(v0, v1, o0, x0, y0, o1, x1, y1, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
